de_pipe_reg: RTL and testbench
==============================

// Module: de_pipe_reg
// PURPOSE
//  ID->DE pipeline register feeding the EXU and read by the RAW hazard unit (rawu).
//  Holds one decoded instruction in de_dff and forwards it to EXU only when rawu pause is low and EXU is ready.
//  A one-entry skid buffer keeps id_ready fully registered.
//  Also counts DE stall cycles and applies pipeline flushes.
// PARAMETERS
//  DW     `DE_REG_WIDTH  width of decoded-instruction bundle (valid bit at `DE_REG_VALID)
//  CW     32             width of saturating stall counter
// PORTS
//  core_clk     in   1    core clock
//  core_rst     in   1    asynchronous, active-high reset
//  id_data      in   DW   decoded bundle from IDU (its `DE_REG_VALID bit is ignored)
//  id_valid     in   1    id_data valid this cycle
//  id_ready     out  1    DE can accept id_data (registered)
//  rawu_pause   in   1    rawu_pause_before_and_exu from rawu (combinational on de_dff)
//  exu_ready    in   1    EXU can take a new instruction (low during multicycle ops)
//  flush        in   1    redirect/exception flush
//  de_dff       out  DW   DE register contents; bit `DE_REG_VALID = de_valid
//  exu_fire     out  1    instruction in de_dff moves to EXU this cycle
//  stall_cnt    out  CW   cycles a valid DE instruction was held
// BEHAVIOUR
//  Reset (async, core_rst=1): de_dff=0 (de_valid=0), skid empty, id_ready=1, stall_cnt=0, exu_fire=0.
//  id_fire = id_valid & id_ready. exu_fire = de_valid & ~rawu_pause & exu_ready (combinational).
//  main_free = ~de_valid | exu_fire.
//  Main register update, priority order:
//   1 flush: de_valid<=0, skid_valid<=0; id_data of the same cycle is dropped.
//   2 main_free & skid_valid: de_dff<=skid; skid_valid<=0, unless id_fire, then skid<=id_data.
//   3 main_free & id_fire: de_dff<=id_data, de_valid<=1.
//   4 main_free, no source: de_valid<=0 (bubble; payload bits may hold stale data).
//   5 ~main_free & id_fire: skid<=id_data, skid_valid<=1.
//  id_ready <= ~skid_valid_next. After flush, id_ready=1 on the next cycle.
//  Because id_ready is registered, id_fire can never occur with the skid full and main held.
//  Program order is strict: skid always drains before new id_data. Both are never lost or duplicated.
//  Pause: while rawu_pause=1, de_dff holds and exu_fire=0. EXU sees a bubble.
//   No combinational loop: rawu reads only the registered de_dff.
//  Latency: id_fire to de_dff = 1 cycle (empty pipe), or 2 cycles via skid.
//   Throughput: 1 instruction/cycle with no pause.
//  stall_cnt: +1 each cycle de_valid & ~exu_fire & ~flush; saturates at 2^CW-1; cleared only by reset.
//  Reset mid-stall: all state drops immediately, including skid. Counting restarts from 0.
// STRUCTURE
//  Shared package/header (core defines): `DE_REG_WIDTH, `DE_REG_VALID, `DE_REG_SRC1/SRC2/DST field macros.
//   Define them there, not locally.
//  Sub-module skid_buf1 (DW-wide one-entry buffer: wr_en, rd_en, data, valid). Main register and counter stay inline.
// TESTING
//  1 Reset, then a stream of 4 id_valid with rawu_pause=0, exu_ready=1
//    -> exu_fire on cycles 1..4 after each accept; stall_cnt=0.
//  2 Instr A in DE, rawu_pause=1 for 3 cycles, id_valid high with B,C
//    -> A held, B in skid, id_ready=0 from next cycle, stall_cnt=3; pause drop -> A,B,C fire in order.
//  3 exu_ready=0 for 2 cycles with rawu_pause=0
//    -> same hold behaviour as test 2; stall_cnt increments by 2.
//  4 flush with A in DE, B in skid, and C on id_data
//    -> next cycle de_valid=0, skid empty, id_ready=1; A,B,C never fire.
//  5 Force stall_cnt to 2^CW-2 (use CW=4, i.e. set to 14), then hold 3 cycles
//    -> stall_cnt saturates at 15.
//  6 Assert core_rst asynchronously mid-cycle while de_valid=1
//    -> de_dff=0 and id_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/de_pipe_reg_pkg.sv
// rtl/de_pipe_reg_pkg.sv - shared decoded-instruction layout for the ID->DE register
`ifndef DE_PIPE_REG_DEFS
`define DE_PIPE_REG_DEFS
`define DE_REG_WIDTH 16
`define DE_REG_VALID 15
`define DE_REG_DST   14:10
`define DE_REG_SRC2  9:5
`define DE_REG_SRC1  4:0
`endif

package de_pipe_reg_pkg;

    localparam int DE_W         = `DE_REG_WIDTH;
    localparam int DE_VALID_BIT = `DE_REG_VALID;

    function automatic logic [4:0] de_dst(input logic [`DE_REG_WIDTH-1:0] d);
        return d[`DE_REG_DST];
    endfunction

    function automatic logic [4:0] de_src1(input logic [`DE_REG_WIDTH-1:0] d);
        return d[`DE_REG_SRC1];
    endfunction

    function automatic logic [4:0] de_src2(input logic [`DE_REG_WIDTH-1:0] d);
        return d[`DE_REG_SRC2];
    endfunction

endpackage

// File: rtl/de_pipe_reg_skid_buf1.sv
// rtl/de_pipe_reg_skid_buf1.sv - one-entry skid buffer; a write in the same cycle as a read wins
module skid_buf1 #(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic          rd_en_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          valid_d_o
);

    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          valid_d;

    always_comb begin
        valid_d = valid_q;
        if (clr_i)        valid_d = 1'b0;
        else if (wr_en_i) valid_d = 1'b1;
        else if (rd_en_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (wr_en_i && !clr_i) data_q <= data_i;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign valid_d_o = valid_d;

endmodule

// File: rtl/de_pipe_reg.sv
// rtl/de_pipe_reg.sv - ID->DE pipeline register with skid buffer, flush and stall counter
module de_pipe_reg
    import de_pipe_reg_pkg::*;
#(
    parameter int DW = `DE_REG_WIDTH,
    parameter int CW = 32
) (
    input  logic          core_clk,
    input  logic          core_rst,
    input  logic [DW-1:0] id_data,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic          rawu_pause,
    input  logic          exu_ready,
    input  logic          flush,
    output logic [DW-1:0] de_dff,
    output logic          exu_fire,
    output logic [CW-1:0] stall_cnt
);

    logic [DW-1:0] de_q, de_d;
    logic          id_ready_q;
    logic [CW-1:0] stall_q, stall_d;

    logic          de_valid, id_fire, main_free;
    logic          skid_wr, skid_rd, skid_valid, skid_valid_d;
    logic [DW-1:0] skid_data;

    assign de_valid  = de_q[DE_VALID_BIT];
    assign id_fire   = id_valid & id_ready_q;
    assign exu_fire  = de_valid & ~rawu_pause & exu_ready;
    assign main_free = ~de_valid | exu_fire;

    // The skid only takes id_data when the main register cannot, or when an older entry must drain first.
    assign skid_wr = ~flush & id_fire & (~main_free | skid_valid);
    assign skid_rd = ~flush & main_free & skid_valid;

    skid_buf1 #(.DW(DW)) u_skid (
        .clk_i     (core_clk),
        .rst_i     (core_rst),
        .clr_i     (flush),
        .wr_en_i   (skid_wr),
        .rd_en_i   (skid_rd),
        .data_i    (id_data),
        .data_o    (skid_data),
        .valid_o   (skid_valid),
        .valid_d_o (skid_valid_d)
    );

    always_comb begin
        de_d = de_q;
        if (flush) begin
            de_d[DE_VALID_BIT] = 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                de_d               = skid_data;
                de_d[DE_VALID_BIT] = 1'b1;
            end else if (id_fire) begin
                de_d               = id_data;
                de_d[DE_VALID_BIT] = 1'b1;
            end else begin
                de_d[DE_VALID_BIT] = 1'b0;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (de_valid && !exu_fire && !flush && !(&stall_q)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            de_q       <= '0;
            id_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            de_q       <= de_d;
            id_ready_q <= ~skid_valid_d;
            stall_q    <= stall_d;
        end
    end

    assign id_ready  = id_ready_q;
    assign de_dff    = de_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// tb/tb_de_pipe_reg.sv - scoreboard bench for de_pipe_reg
module tb_de_pipe_reg;
    import de_pipe_reg_pkg::*;

    localparam int CW = 4;
    localparam logic [DE_W-1:0] VMASK = 16'h8000;

    logic            core_clk = 1'b0;
    logic            core_rst = 1'b1;
    logic [DE_W-1:0] id_data  = '0;
    logic            id_valid = 1'b0;
    logic            id_ready;
    logic            rawu_pause = 1'b0;
    logic            exu_ready  = 1'b1;
    logic            flush      = 1'b0;
    logic [DE_W-1:0] de_dff;
    logic            exu_fire;
    logic [CW-1:0]   stall_cnt;

    int tests = 0;
    int failed = 0;
    int fired_cnt = 0;
    logic [DE_W-1:0] sb_q[$];

    de_pipe_reg #(.DW(DE_W), .CW(CW)) dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .id_data    (id_data),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .rawu_pause (rawu_pause),
        .exu_ready  (exu_ready),
        .flush      (flush),
        .de_dff     (de_dff),
        .exu_fire   (exu_fire),
        .stall_cnt  (stall_cnt)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic do_reset();
        core_rst = 1'b1;
        id_valid = 1'b0;
        rawu_pause = 1'b0;
        exu_ready = 1'b1;
        flush = 1'b0;
        sb_q.delete();
        step();
        step();
        core_rst = 1'b0;
    endtask

    // Monitor: retire on exu_fire, then record accepted instructions in program order.
    always @(negedge core_clk) begin
        if (core_rst) begin
            sb_q.delete();
        end else begin
            if (exu_fire) begin
                fired_cnt++;
                if (sb_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_fire: got %h expected no fire at %0t", de_dff, $time);
                end else begin
                    check("fire_order", {16'h0, de_dff}, {16'h0, sb_q.pop_front()});
                end
            end
            if (flush) sb_q.delete();
            if (id_valid && id_ready && !flush) sb_q.push_back(id_data | VMASK);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DE_W-1:0] stream [4];
        stream[0] = 16'h1001; stream[1] = 16'h2002; stream[2] = 16'h3003; stream[3] = 16'h4004;

        // reset state
        do_reset();
        check("rst_de_dff", {16'h0, de_dff}, 32'h0);
        check("rst_id_ready", {31'h0, id_ready}, 32'h1);
        check("rst_stall", {28'h0, stall_cnt}, 32'h0);
        check("rst_exu_fire", {31'h0, exu_fire}, 32'h0);

        // test 1: back-to-back stream
        for (int k = 0; k < 4; k++) begin
            id_valid = 1'b1;
            id_data  = stream[k];
            step();
            check("t1_fire", {31'h0, exu_fire}, 32'h1);
            check("t1_de", {16'h0, de_dff}, {16'h0, stream[k] | VMASK});
        end
        id_valid = 1'b0;
        step();
        step();
        check("t1_stall", {28'h0, stall_cnt}, 32'h0);
        check("t1_fired", fired_cnt, 32'd4);

        // test 2: rawu pause holds A, B goes to skid
        id_valid = 1'b1; id_data = 16'h0a11;
        step();
        rawu_pause = 1'b1; id_data = 16'h0b22;
        step();
        check("t2_ready_low", {31'h0, id_ready}, 32'h0);
        id_data = 16'h0c33;
        step();
        step();
        check("t2_stall", {28'h0, stall_cnt}, 32'd3);
        check("t2_hold", {16'h0, de_dff}, 32'h8a11);
        check("t2_ready_held", {31'h0, id_ready}, 32'h0);
        rawu_pause = 1'b0;
        step();
        check("t2_skid_drain", {16'h0, de_dff}, 32'h8b22);
        check("t2_ready_back", {31'h0, id_ready}, 32'h1);
        step();
        check("t2_c_in", {16'h0, de_dff}, 32'h8c33);
        id_valid = 1'b0;
        step();
        step();
        check("t2_stall_end", {28'h0, stall_cnt}, 32'd3);
        check("t2_fired", fired_cnt, 32'd7);

        // test 3: exu busy for 2 cycles
        id_valid = 1'b1; id_data = 16'h0d44;
        step();
        exu_ready = 1'b0; id_data = 16'h0e55;
        step();
        id_data = 16'h0f66;
        step();
        check("t3_stall", {28'h0, stall_cnt}, 32'd5);
        check("t3_ready_low", {31'h0, id_ready}, 32'h0);
        check("t3_hold", {16'h0, de_dff}, 32'h8d44);
        exu_ready = 1'b1;
        step();
        step();
        id_valid = 1'b0;
        step();
        step();
        check("t3_fired", fired_cnt, 32'd10);

        // test 4: flush with A in DE, B in skid, C on id_data
        id_valid = 1'b1; id_data = 16'h1111;
        step();
        rawu_pause = 1'b1; id_data = 16'h2222;
        step();
        id_data = 16'h3333;
        flush = 1'b1;
        step();
        flush = 1'b0; id_valid = 1'b0;
        check("t4_de_valid", {31'h0, de_dff[DE_VALID_BIT]}, 32'h0);
        check("t4_ready", {31'h0, id_ready}, 32'h1);
        check("t4_stall", {28'h0, stall_cnt}, 32'd6);
        rawu_pause = 1'b0;
        step();
        step();
        step();
        check("t4_no_fire", fired_cnt, 32'd10);
        check("t4_sb_empty", sb_q.size(), 32'd0);

        // test 5: stall counter saturation
        do_reset();
        id_valid = 1'b1; id_data = 16'h0777;
        step();
        rawu_pause = 1'b1; id_valid = 1'b0;
        repeat (14) step();
        check("t5_stall14", {28'h0, stall_cnt}, 32'd14);
        repeat (3) step();
        check("t5_sat", {28'h0, stall_cnt}, 32'd15);
        rawu_pause = 1'b0;
        step();
        check("t5_sat_hold", {28'h0, stall_cnt}, 32'd15);
        check("t5_fired", fired_cnt, 32'd11);

        // test 6: asynchronous reset mid-cycle
        id_valid = 1'b1; id_data = 16'h5555;
        step();
        rawu_pause = 1'b1; id_data = 16'h6666;
        step();
        id_valid = 1'b0;
        check("t6_pre_valid", {31'h0, de_dff[DE_VALID_BIT]}, 32'h1);
        @(negedge core_clk);
        #2;
        core_rst = 1'b1;
        #1;
        check("t6_de_dff", {16'h0, de_dff}, 32'h0);
        check("t6_ready", {31'h0, id_ready}, 32'h1);
        check("t6_stall", {28'h0, stall_cnt}, 32'h0);
        check("t6_exu_fire", {31'h0, exu_fire}, 32'h0);
        do_reset();
        step();
        check("t6_post_fired", fired_cnt, 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
